// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K&S core: sequences fetch/decode/execute and drives data_path strobes.
// Optional overflow branches (I_BOV / I_BNOV) are enabled with `define KS_OVF_BRANCH_EN.

package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_LOAD_IR  = 4'd1,
        S_DECODE   = 4'd2,
        S_ALU      = 4'd3,
        S_MOVE     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_LOAD_WB  = 4'd6,
        S_STORE_WR = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_type;

endpackage

module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    localparam int OB_HALT  = 10;
    localparam int OB_BR    = 9;
    localparam int OB_PC    = 8;
    localparam int OB_IR    = 7;
    localparam int OB_ADDR  = 6;
    localparam int OB_CSEL  = 5;
    localparam int OB_OP_HI = 4;
    localparam int OB_OP_LO = 3;
    localparam int OB_WR    = 2;
    localparam int OB_FL    = 1;
    localparam int OB_RAM   = 0;

    state_type               state_q, state_d;
    decoded_instruction_type instr_q, instr_d;
    logic [10:0]             out_q, out_d;
    logic                    take_s;

    function automatic logic [1:0] alu_op(input decoded_instruction_type i);
        logic [1:0] op;
        case (i)
            I_SUB:   op = 2'b01;
            I_AND:   op = 2'b10;
            I_OR:    op = 2'b11;
            default: op = 2'b00;
        endcase
        return op;
    endfunction

    // Output vector of a state; the instruction only matters for the ALU op field.
    function automatic logic [10:0] moore_outputs(input state_type s, input decoded_instruction_type i);
        logic [10:0] o;
        o = 11'd0;
        case (s)
            S_LOAD_IR:  o[OB_IR] = 1'b1;
            S_DECODE:   o[OB_PC] = 1'b1;
            S_ALU: begin
                o[OB_WR]             = 1'b1;
                o[OB_FL]             = 1'b1;
                o[OB_OP_HI:OB_OP_LO] = alu_op(i);
            end
            S_MOVE:     o[OB_WR] = 1'b1;
            S_MEM_ADDR: o[OB_ADDR] = 1'b1;
            S_LOAD_WB: begin
                o[OB_ADDR] = 1'b1;
                o[OB_CSEL] = 1'b1;
                o[OB_WR]   = 1'b1;
            end
            S_STORE_WR: begin
                o[OB_ADDR] = 1'b1;
                o[OB_RAM]  = 1'b1;
            end
            S_BRANCH: begin
                o[OB_BR] = 1'b1;
                o[OB_PC] = 1'b1;
            end
            S_HALT:     o[OB_HALT] = 1'b1;
            default:    o = 11'd0;
        endcase
        return o;
    endfunction

    // Conditional-branch resolution on the flags present during DECODE.
    always_comb begin
        take_s = 1'b0;
        case (decoded_instruction)
            I_BZERO:  take_s = zero_op;
            I_BNZERO: take_s = ~zero_op;
            I_BNEG:   take_s = neg_op;
            I_BNNEG:  take_s = ~neg_op;
`ifdef KS_OVF_BRANCH_EN
            I_BOV:    take_s = unsigned_overflow | signed_overflow;
            I_BNOV:   take_s = ~(unsigned_overflow | signed_overflow);
`endif
            default:  take_s = 1'b0;
        endcase
    end

`ifndef KS_OVF_BRANCH_EN
    logic unused_ovf_s;
    assign unused_ovf_s = unsigned_overflow ^ signed_overflow;
`endif

    // Next-state logic; the instruction is captured only in DECODE.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH:   state_d = S_LOAD_IR;
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                instr_d = decoded_instruction;
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
                    I_MOVE:                    state_d = S_MOVE;
                    I_LOAD, I_STORE:           state_d = S_MEM_ADDR;
                    I_BRANCH:                  state_d = S_BRANCH;
                    I_HALT:                    state_d = S_HALT;
                    default:                   state_d = take_s ? S_BRANCH : S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (instr_q == I_STORE) begin
                    state_d = S_STORE_WR;
                end else begin
                    state_d = S_LOAD_WB;
                end
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are precomputed from the next state so they register alongside it.
    always_comb begin
        out_d = moore_outputs(state_d, instr_d);
    end

    // State, latched instruction and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            instr_q <= I_NOP;
            out_q   <= 11'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            out_q   <= out_d;
        end
    end

    assign halt             = out_q[OB_HALT];
    assign branch           = out_q[OB_BR];
    assign pc_enable        = out_q[OB_PC];
    assign ir_enable        = out_q[OB_IR];
    assign addr_sel         = out_q[OB_ADDR];
    assign c_sel            = out_q[OB_CSEL];
    assign operation        = out_q[OB_OP_HI:OB_OP_LO];
    assign write_reg_enable = out_q[OB_WR];
    assign flags_reg_enable = out_q[OB_FL];
    assign ram_write_enable = out_q[OB_RAM];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand sequences, random stream vs reference model.
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam logic [10:0] E_HALT = 11'h400;
    localparam logic [10:0] E_BR   = 11'h200;
    localparam logic [10:0] E_PC   = 11'h100;
    localparam logic [10:0] E_IR   = 11'h080;
    localparam logic [10:0] E_ADDR = 11'h040;
    localparam logic [10:0] E_CSEL = 11'h020;
    localparam logic [10:0] E_WR   = 11'h004;
    localparam logic [10:0] E_FL   = 11'h002;
    localparam logic [10:0] E_RAM  = 11'h001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoded_instruction_type di;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
    logic [10:0] obs;

    int total_cnt = 0;
    int pass_cnt = 0;

    int m_len;
    logic m_halt;
    logic [10:0] m_tr [0:5];

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
        .zero_op(zero_op), .neg_op(neg_op),
        .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
        .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
        .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
        .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
        .ram_write_enable(ram_write_enable), .halt(halt)
    );

    assign obs = {halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                  write_reg_enable, flags_reg_enable, ram_write_enable};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] fl);
        di = decoded_instruction_type'(op);
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = fl;
    endtask

    // Called at a negedge: drive this cycle's inputs, check outputs, advance one cycle.
    task automatic step(input logic [4:0] op, input logic [3:0] fl, input logic rst_v,
                        input logic [10:0] exp, input string name);
        drive(op, fl);
        rst_n = rst_v;
        chk(name, {21'd0, obs}, {21'd0, exp});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", {21'd0, obs}, 32'd0);
    endtask

    // Instruction-level reference: per-cycle expected outputs from FETCH entry.
    task automatic model(input logic [4:0] op, input logic [3:0] fl);
        logic z, n, ov, taken;
        z = fl[3]; n = fl[2]; ov = fl[1] | fl[0];
        m_tr[0] = 11'd0; m_tr[1] = E_IR; m_tr[2] = E_PC;
        m_len = 3; m_halt = 1'b0; taken = 1'b0;
        case (op)
            5'd9:  taken = z;
            5'd10: taken = !z;
            5'd11: taken = n;
            5'd12: taken = !n;
`ifdef KS_OVF_BRANCH_EN
            5'd13: taken = ov;
            5'd14: taken = !ov;
`endif
            default: taken = 1'b0;
        endcase
        case (op)
            5'd4: begin m_tr[3] = E_WR | E_FL;            m_len = 4; end
            5'd5: begin m_tr[3] = E_WR | E_FL | 11'h008;  m_len = 4; end
            5'd6: begin m_tr[3] = E_WR | E_FL | 11'h010;  m_len = 4; end
            5'd7: begin m_tr[3] = E_WR | E_FL | 11'h018;  m_len = 4; end
            5'd3: begin m_tr[3] = E_WR;                   m_len = 4; end
            5'd1: begin m_tr[3] = E_ADDR; m_tr[4] = E_ADDR | E_CSEL | E_WR; m_len = 5; end
            5'd2: begin m_tr[3] = E_ADDR; m_tr[4] = E_ADDR | E_RAM;         m_len = 5; end
            5'd8: begin m_tr[3] = E_BR | E_PC;            m_len = 4; end
            5'd15: m_halt = 1'b1;
            default: begin
                if (taken) begin m_tr[3] = E_BR | E_PC; m_len = 4; end
            end
        endcase
    endtask

    // Runs one instruction; junk on the instruction/flag inputs outside DECODE.
    task automatic run_instr(input logic [4:0] op, input logic [3:0] fl, input string name);
        model(op, fl);
        for (int c = 0; c < m_len; c++) begin
            if (c == 2) step(op, fl, 1'b1, m_tr[c], name);
            else step(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'b1, m_tr[c], name);
        end
        if (m_halt) begin
            for (int k = 0; k < 20; k++)
                step(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'b1, E_HALT, "halt_hold");
            do_reset();
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  fl;
        int          cycles;
        logic [10:0] seen;
        string       name;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int cyc;
        logic [10:0] seen;
        drive(5'd0, 4'd0);

        vecs.push_back('{5'd0,  4'h0, 3, 11'h180, "nop"});
        vecs.push_back('{5'd4,  4'h0, 4, 11'h186, "add"});
        vecs.push_back('{5'd5,  4'h0, 4, 11'h18E, "sub"});
        vecs.push_back('{5'd6,  4'h0, 4, 11'h196, "and"});
        vecs.push_back('{5'd7,  4'h0, 4, 11'h19E, "or"});
        vecs.push_back('{5'd3,  4'h0, 4, 11'h184, "move"});
        vecs.push_back('{5'd1,  4'h0, 5, 11'h1E4, "load"});
        vecs.push_back('{5'd2,  4'h0, 5, 11'h1C1, "store"});
        vecs.push_back('{5'd8,  4'h0, 4, 11'h380, "branch"});
        vecs.push_back('{5'd9,  4'h8, 4, 11'h380, "bzero_taken"});
        vecs.push_back('{5'd9,  4'h0, 3, 11'h180, "bzero_not"});
        vecs.push_back('{5'd10, 4'h0, 4, 11'h380, "bnzero_taken"});
        vecs.push_back('{5'd10, 4'h8, 3, 11'h180, "bnzero_not"});
        vecs.push_back('{5'd11, 4'h4, 4, 11'h380, "bneg_taken"});
        vecs.push_back('{5'd12, 4'h4, 3, 11'h180, "bnneg_not"});
        vecs.push_back('{5'd20, 4'hF, 3, 11'h180, "unknown_op"});
`ifdef KS_OVF_BRANCH_EN
        vecs.push_back('{5'd13, 4'h1, 4, 11'h380, "bov_sov"});
        vecs.push_back('{5'd13, 4'h0, 3, 11'h180, "bov_not"});
        vecs.push_back('{5'd14, 4'h0, 4, 11'h380, "bnov_taken"});
`else
        vecs.push_back('{5'd13, 4'h1, 3, 11'h180, "bov_as_nop"});
        vecs.push_back('{5'd14, 4'h0, 3, 11'h180, "bnov_as_nop"});
`endif

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fl);
            chk({vecs[i].name, "_start"}, {21'd0, obs}, 32'd0);
            seen = obs;
            cyc = 1;
            while (cyc < 12) begin
                @(negedge clk);
                if (obs == 11'd0) break;
                seen |= obs;
                cyc++;
            end
            chk({vecs[i].name, "_cycles"}, cyc, vecs[i].cycles);
            chk({vecs[i].name, "_outputs"}, {21'd0, seen}, {21'd0, vecs[i].seen});
        end

        // Reset in MEM_ADDR of a STORE must suppress the write and return to FETCH.
        step(5'd0, 4'h0, 1'b1, 11'd0, "rst_mid_fetch");
        step(5'd0, 4'h0, 1'b1, E_IR, "rst_mid_loadir");
        step(5'd2, 4'h0, 1'b1, E_PC, "rst_mid_decode");
        step(5'd2, 4'h0, 1'b0, E_ADDR, "rst_mid_memaddr");
        step(5'd2, 4'h0, 1'b1, 11'd0, "rst_mid_after");
        step(5'd2, 4'h0, 1'b1, E_IR, "rst_mid_loadir2");
        step(5'd0, 4'h0, 1'b1, E_PC, "rst_mid_decode2");

        // HALT absorbs for 20 cycles, then a reset recovers.
        run_instr(5'd15, 4'h0, "halt");
        run_instr(5'd5, 4'h0, "sub_after_halt");

        for (int i = 0; i < 300; i++)
            run_instr(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), "random");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
